coin_panel_encoder: RTL and testbench

Front-end encoder that drives the 3-bit command bus of the candy vending controller. It synchronizes and debounces four raw panel inputs (1-unit coin sensor, 5-unit coin sensor, candy button, change button), queues the resulting events, and emits each one as a single-cycle command code followed by a fixed idle gap. Optionally, it uses the controller's `sum` feedback to reject coins that would push the credit above 10 and pulses a coin-return output instead.

---
 rtl/coin_panel_encoder.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_coin_panel_encoder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_panel_encoder.sv
// coin_panel_encoder: synchronise/debounce four panel inputs, queue events, emit one-cycle command codes.
// Latency: code valid after edge DEBOUNCE_CYCLES+4 from first raw-high sample; 5-cycle period under load.
// Backpressure: pending flags hold while the queue is full; re-hit of a held flag sets sticky overflow.
// Optional feature: define COIN_REJECT_EN to reject coins that would push credit above 10.

// Small circular event queue; push ignored when full, pop ignored when empty.
module coin_panel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full     = (cnt_q == FULL_CNT);
    assign empty    = (cnt_q == '0);
    assign level    = cnt_q;
    assign head_dat = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; simultaneous push/pop keeps the count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_push  = push_vld && !full;
        do_pop   = pop_vld && !empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module coin_panel_encoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          coin1_raw,
    input  logic                          coin5_raw,
    input  logic                          candy_btn_raw,
    input  logic                          change_btn_raw,
    input  logic [3:0]                    sum,
    output logic [2:0]                    code,
    output logic                          code_valid,
    output logic                          coin_reject,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    // Event identifiers double as bit positions in the per-input vectors.
    localparam logic [1:0] EV_COIN1  = 2'd0;
    localparam logic [1:0] EV_COIN5  = 2'd1;
    localparam logic [1:0] EV_CANDY  = 2'd2;
    localparam logic [1:0] EV_CHANGE = 2'd3;

    localparam logic [2:0] CODE_IDLE   = 3'b111;
    localparam logic [2:0] CODE_COIN1  = 3'b001;
    localparam logic [2:0] CODE_COIN5  = 3'b010;
    localparam logic [2:0] CODE_CANDY  = 3'b101;
    localparam logic [2:0] CODE_CHANGE = 3'b110;

    // Counter value on which the next differing sample completes the stable run.
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    logic [3:0] raw;
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] level_q, level_d;
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];
    logic [3:0] rise;

    logic [3:0] pend_q, pend_d;
    logic [3:0] grant;
    logic       overflow_q, overflow_d;

    logic       push_vld;
    logic [1:0] push_dat;
    logic       pop_vld;
    logic [1:0] head_dat;
    logic       fifo_full, fifo_empty;

    state_t     state_q, state_d;
    logic [1:0] gap_cnt_q, gap_cnt_d;
    logic [2:0] code_q, code_d;
    logic       code_valid_q, code_valid_d;
    logic       reject_q, reject_d;
    logic [2:0] head_code;
    logic       reject_hit;

    assign raw = {change_btn_raw, candy_btn_raw, coin5_raw, coin1_raw};

    // Two-stage synchroniser and debounce: a level flips only after DEBOUNCE_CYCLES differing samples.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        rise    = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    level_d[i] = sync2_q[i];
                    rise[i]    = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // Fixed-priority arbiter moves one pending event per cycle into the queue when there is room.
    always_comb begin
        grant    = '0;
        push_vld = 1'b0;
        push_dat = EV_COIN1;
        if (!fifo_full) begin
            if (pend_q[EV_COIN5]) begin
                grant[EV_COIN5] = 1'b1;
                push_dat        = EV_COIN5;
            end else if (pend_q[EV_COIN1]) begin
                grant[EV_COIN1] = 1'b1;
                push_dat        = EV_COIN1;
            end else if (pend_q[EV_CANDY]) begin
                grant[EV_CANDY] = 1'b1;
                push_dat        = EV_CANDY;
            end else if (pend_q[EV_CHANGE]) begin
                grant[EV_CHANGE] = 1'b1;
                push_dat         = EV_CHANGE;
            end
            push_vld = |grant;
        end
        // A flag granted this cycle is free, so a same-cycle rise replaces it without loss.
        pend_d     = (pend_q & ~grant) | rise;
        overflow_d = overflow_q | (|(rise & pend_q & ~grant));
    end

    coin_panel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    // Map the queue head to its command code.
    always_comb begin
        head_code = CODE_COIN1;
        case (head_dat)
            EV_COIN1:  head_code = CODE_COIN1;
            EV_COIN5:  head_code = CODE_COIN5;
            EV_CANDY:  head_code = CODE_CANDY;
            EV_CHANGE: head_code = CODE_CHANGE;
            default:   head_code = CODE_COIN1;
        endcase
    end

`ifdef COIN_REJECT_EN
    // Coins that would take the credit past 10 are returned instead of forwarded.
    always_comb begin
        reject_hit = ((head_dat == EV_COIN1) && (sum == 4'd10)) ||
                     ((head_dat == EV_COIN5) && (sum > 4'd5));
    end
`else
    logic unused_sum;
    assign unused_sum = ^sum;
    assign reject_hit = 1'b0;
`endif

    // Output FSM: pop into a one-cycle DRIVE slot, then a 3-cycle GAP so the controller's sum settles.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        code_d    = CODE_IDLE;
        reject_d  = 1'b0;
        pop_vld   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_vld = 1'b1;
                    state_d = ST_DRIVE;
                    if (reject_hit) begin
                        reject_d = 1'b1;
                    end else begin
                        code_d = head_code;
                    end
                end
            end
            ST_DRIVE: begin
                state_d   = ST_GAP;
                gap_cnt_d = 2'd0;
            end
            ST_GAP: begin
                if (gap_cnt_q == 2'd2) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        code_valid_d = (code_d != CODE_IDLE);
    end

    // All state registers; reset returns outputs to idle and drops anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            pend_q       <= '0;
            overflow_q   <= 1'b0;
            state_q      <= ST_IDLE;
            gap_cnt_q    <= '0;
            code_q       <= CODE_IDLE;
            code_valid_q <= 1'b0;
            reject_q     <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pend_q       <= pend_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            reject_q     <= reject_d;
        end
    end

    assign code        = code_q;
    assign code_valid  = code_valid_q;
    assign coin_reject = reject_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_coin_panel_encoder.sv
// tb_coin_panel_encoder: directed checks of debounce latency, priority, rejection, overflow and reset.
// Latency: u_dut uses DEBOUNCE_CYCLES=4 (code after edge 8); u_dut2 uses 2 with a 2-deep queue.
// Backpressure: u_dut2 is overdriven with coin1 pulses to fill its queue and raise overflow.
module tb_coin_panel_encoder;
    logic       clk;
    logic       reset;
    logic       coin1_raw, coin5_raw, candy_btn_raw, change_btn_raw;
    logic [3:0] sum;

    logic [2:0] code_a, code_b;
    logic       code_valid_a, code_valid_b;
    logic       reject_a, reject_b;
    logic       ovf_a, ovf_b;
    logic [2:0] level_a;
    logic [1:0] level_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int start;

    int q_code[$];
    int q_cyc[$];
    int rej_cnt;
    int max_level;
    int vld_err;
    int b_cnt, b_bad, b_close, b_last;

    coin_panel_encoder #(
        .DEBOUNCE_CYCLES (4),
        .FIFO_DEPTH      (4)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .coin1_raw      (coin1_raw),
        .coin5_raw      (coin5_raw),
        .candy_btn_raw  (candy_btn_raw),
        .change_btn_raw (change_btn_raw),
        .sum            (sum),
        .code           (code_a),
        .code_valid     (code_valid_a),
        .coin_reject    (reject_a),
        .overflow       (ovf_a),
        .fifo_level     (level_a)
    );

    coin_panel_encoder #(
        .DEBOUNCE_CYCLES (2),
        .FIFO_DEPTH      (2)
    ) u_dut2 (
        .clk            (clk),
        .reset          (reset),
        .coin1_raw      (coin1_raw),
        .coin5_raw      (coin5_raw),
        .candy_btn_raw  (candy_btn_raw),
        .change_btn_raw (change_btn_raw),
        .sum            (sum),
        .code           (code_b),
        .code_valid     (code_valid_b),
        .coin_reject    (reject_b),
        .overflow       (ovf_b),
        .fifo_level     (level_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record everything the DUTs emit, sampled mid-cycle.
    always @(negedge clk) begin
        if (code_valid_a) begin
            q_code.push_back(int'(code_a));
            q_cyc.push_back(cyc);
        end
        if (code_valid_a != (code_a != 3'b111)) vld_err++;
        if (reject_a) rej_cnt++;
        if (int'(level_a) > max_level) max_level = int'(level_a);
        if (code_valid_b) begin
            b_cnt++;
            if (code_b != 3'b001) b_bad++;
            if (cyc - b_last < 5) b_close++;
            b_last = cyc;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_mon();
        q_code.delete();
        q_cyc.delete();
        rej_cnt   = 0;
        max_level = 0;
        b_cnt     = 0;
        b_bad     = 0;
        b_close   = 0;
        b_last    = -100;
    endtask

    task automatic set_all(input logic v);
        coin1_raw      = v;
        coin5_raw      = v;
        candy_btn_raw  = v;
        change_btn_raw = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_all(1'b0);
        tick(3);
        reset = 1'b0;
        tick(2);
        clr_mon();
    endtask

    // Hold one coin input high long enough to debounce, release it and let the FSM drain.
    task automatic coin_event(input bit five);
        clr_mon();
        if (five) coin5_raw = 1'b1; else coin1_raw = 1'b1;
        tick(12);
        coin1_raw = 1'b0;
        coin5_raw = 1'b0;
        tick(30);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got 0 expected 1 (simulation did not finish)");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        set_all(1'b0);
        sum = 4'd0;
        vld_err = 0;
        clr_mon();
        tick(2);
        // Outputs while held in reset.
        chk("rst_code",     int'(code_a), 7);
        chk("rst_valid",    int'(code_valid_a), 0);
        chk("rst_reject",   int'(reject_a), 0);
        chk("rst_overflow", int'(ovf_a), 0);
        chk("rst_level",    int'(level_a), 0);
        reset = 1'b0;
        tick(2);
        clr_mon();

        // Held coin1: pending at edge 6, push at 7, code 001 only in the cycle after edge 8.
        coin1_raw = 1'b1;
        start = cyc;
        tick(7);
        chk("t1_level_e7", int'(level_a), 1);
        chk("t1_code_e7",  int'(code_a), 7);
        tick(1);
        chk("t1_code_e8",  int'(code_a), 1);
        chk("t1_valid_e8", int'(code_valid_a), 1);
        tick(1);
        chk("t1_code_e9",  int'(code_a), 7);
        tick(20);
        coin1_raw = 1'b0;
        tick(20);
        chk("t1_count", q_code.size(), 1);
        if (q_code.size() > 0) begin
            chk("t1_cyc", q_cyc[0] - start, 8);
        end

        // Bouncing coin1: 3 high / 1 low never gives 4 stable samples.
        clr_mon();
        repeat (6) begin
            coin1_raw = 1'b1;
            tick(3);
            coin1_raw = 1'b0;
            tick(1);
        end
        tick(30);
        chk("t1_bounce_count", q_code.size(), 0);

        // All four rise together: priority order, 5-cycle spacing, queue peaks at 3.
        do_reset();
        set_all(1'b1);
        start = cyc;
        tick(40);
        chk("t2_count", q_code.size(), 4);
        if (q_code.size() == 4) begin
            chk("t2_code0", q_code[0], 2);
            chk("t2_code1", q_code[1], 1);
            chk("t2_code2", q_code[2], 5);
            chk("t2_code3", q_code[3], 6);
            chk("t2_first", q_cyc[0] - start, 8);
            for (int i = 1; i < 4; i++) begin
                chk("t2_spacing", q_cyc[i] - q_cyc[i-1], 5);
            end
        end
        chk("t2_peak_level", max_level, 3);
        set_all(1'b0);
        tick(20);

        // Coin rejection (enabled build) or straight forwarding (default build).
`ifdef COIN_REJECT_EN
        do_reset();
        sum = 4'd6;
        coin_event(1'b1);
        chk("t3_c5_count",  q_code.size(), 0);
        chk("t3_c5_reject", rej_cnt, 1);
        sum = 4'd10;
        coin_event(1'b0);
        chk("t3_c1_count",  q_code.size(), 0);
        chk("t3_c1_reject", rej_cnt, 1);
`else
        do_reset();
        sum = 4'd10;
        coin_event(1'b1);
        chk("t6_c5_count",  q_code.size(), 1);
        if (q_code.size() == 1) chk("t6_c5_code", q_code[0], 2);
        chk("t6_c5_reject", rej_cnt, 0);
`endif
        sum = 4'd9;
        coin_event(1'b0);
        chk("t3_c1_ok_count",  q_code.size(), 1);
        if (q_code.size() == 1) chk("t3_c1_ok_code", q_code[0], 1);
        chk("t3_c1_ok_reject", rej_cnt, 0);
        sum = 4'd0;

        // Reset during DRIVE: coin5 on the bus, coin1 queued, candy/change still pending.
        do_reset();
        set_all(1'b1);
        tick(8);
        chk("t5_drive_code",  int'(code_a), 2);
        chk("t5_drive_level", int'(level_a), 1);
        reset = 1'b1;
        set_all(1'b0);
        #1;
        chk("t5_rst_code",  int'(code_a), 7);
        chk("t5_rst_valid", int'(code_valid_a), 0);
        chk("t5_rst_level", int'(level_a), 0);
        clr_mon();
        tick(3);
        reset = 1'b0;
        tick(40);
        chk("t5_stale_count", q_code.size(), 0);

        // Overdrive the 2-deep, 2-cycle-debounce instance with coin1 at one event per 4 cycles.
        do_reset();
        repeat (40) begin
            coin1_raw = 1'b1;
            tick(2);
            coin1_raw = 1'b0;
            tick(2);
        end
        tick(60);
        chk("t4_overflow",   int'(ovf_b), 1);
        chk("t4_bad_code",   b_bad, 0);
        chk("t4_spacing",    b_close, 0);
        chk("t4_count_rng",  int'(b_cnt >= 30 && b_cnt <= 39), 1);
        chk("t4_a_overflow", int'(ovf_a), 0);
        chk("t4_a_count",    q_code.size(), 0);

        chk("valid_matches_code", vld_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
